// File: rtl/pattern_delay_timer.sv
// pattern_delay_timer: one-shot delay timer armed by a serial start pattern.
// After PATTERN is seen on data, the next DELAY_W bits (MSB first) are
// shifted into the delay register. The timer then counts (delay+1)*TICKS
// cycles and raises done until ack is seen.
// Optional build macro TIMER_ABORT_EN adds a synchronous abort input.
//
// state  | meaning
// -------+------------------------------------------------------------
// SEARCH | shifting data into history, looking for PATTERN
// SHIFT  | shift_ena high, loading DELAY_W delay bits from data
// COUNT  | counting high, TICKS cycles per delay unit, down to zero
// DONE   | done high, waiting for ack
module pattern_delay_timer #(
  parameter int                 PAT_W   = 4,
  parameter logic [PAT_W-1:0]   PATTERN = 4'b1101,
  parameter int                 DELAY_W = 4,
  parameter int                 TICKS   = 1000
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               data,
  input  logic               ack,
`ifdef TIMER_ABORT_EN
  input  logic               abort,
`endif
  output logic               shift_ena,
  output logic               counting,
  output logic               done,
  output logic [DELAY_W-1:0] count
);

  localparam int TICK_W = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam int BIT_W  = (DELAY_W > 1) ? $clog2(DELAY_W) : 1;
  localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(TICKS - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST    = BIT_W'(DELAY_W - 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SHIFT  = 2'd1,
    COUNT  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state, state_nxt;

  // Only the newest PAT_W-1 bits are kept; the incoming bit completes the window.
  logic [PAT_W-2:0]   history;
  logic [PAT_W-1:0]   history_shifted;
  logic [DELAY_W-1:0] delay;
  logic [BIT_W-1:0]   bit_cnt;
  logic [TICK_W-1:0]  tick;
  logic               abort_i;

`ifdef TIMER_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  assign history_shifted = {history, data};

  // State register; reset returns to SEARCH from anywhere.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= SEARCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; abort overrides every other transition.
  always_comb begin
    state_nxt = state;
    case (state)
      SEARCH: if (history_shifted == PATTERN) state_nxt = SHIFT;
      SHIFT:  if (bit_cnt == BIT_LAST) state_nxt = COUNT;
      COUNT:  if ((tick == '0) && (delay == '0)) state_nxt = DONE;
      DONE:   if (ack) state_nxt = SEARCH;
      default: state_nxt = SEARCH;
    endcase
    if (abort_i) state_nxt = SEARCH;
  end

  // Datapath: pattern history, delay shift/decrement, bit and tick counters.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      history <= '0;
      delay   <= '0;
      bit_cnt <= '0;
      tick    <= '0;
    end else if (abort_i) begin
      history <= '0;
      delay   <= '0;
      bit_cnt <= '0;
      tick    <= '0;
    end else begin
      case (state)
        SEARCH: begin
          history <= history_shifted[PAT_W-2:0];
          bit_cnt <= '0;
        end
        SHIFT: begin
          delay   <= {delay[DELAY_W-2:0], data};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) tick <= TICK_RELOAD;
        end
        COUNT: begin
          if (tick != '0) begin
            tick <= tick - 1'b1;
          end else if (delay != '0) begin
            delay <= delay - 1'b1;
            tick  <= TICK_RELOAD;
          end
        end
        DONE: begin
          // Clearing history keeps bits seen before the ack out of the next match.
          if (ack) history <= '0;
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from state and the delay register only.
  assign shift_ena = (state == SHIFT);
  assign counting  = (state == COUNT);
  assign done      = (state == DONE);
  // delay is already zero in DONE and after completion, so it can drive count directly.
  assign count     = delay;

endmodule
